s_axis_video_rx: RTL and testbench
==================================

// Module: s_axis_video_rx
// PURPOSE
//  Input stage of the gradient pipeline: AXI4-Stream video slave feeding the kernel/line-buffer stage
//  with a pixel/valid/start-of-frame triple. Tracks x/y position against IMG_WIDTH x IMG_HEIGHT and
//  validates tuser (SOF) and tlast (EOL). Malformed frames are dropped until the next SOF so the
//  downstream counters never desynchronise. Reports errors via pulses and a saturating counter.
// PARAMETERS
//  DATA_WIDTH  8   pixel width, bits
//  IMG_WIDTH   10  pixels per line, 2..4095
//  IMG_HEIGHT  10  lines per frame, 2..4095
// PORTS
//  i_clk             in   1           clock
//  i_aresetn         in   1           async reset, active low
//  s_axis_tdata      in   DATA_WIDTH  input pixel
//  s_axis_tvalid     in   1           input beat valid
//  s_axis_tuser      in   1           SOF marker, first pixel of frame
//  s_axis_tlast      in   1           EOL marker, last pixel of line
//  s_axis_tready     out  1           slave ready
//  o_pixel           out  DATA_WIDTH  pixel to next stage
//  o_pixel_valid     out  1           o_pixel valid, 1-cycle strobe per accepted in-frame beat
//  o_start_of_frame  out  1           high with o_pixel_valid on pixel (0,0) only
//  o_frame_done      out  1           1-cycle pulse with the last pixel (W-1,H-1)
//  o_err_pulse       out  1           1-cycle pulse on any geometry error
//  o_err_count       out  16          saturating count of errors since reset
// BEHAVIOUR
//  Reset (async, i_aresetn=0): all outputs 0, x=y=0, state WAIT_SOF. s_axis_tready registered: 0 in
//   reset, 1 from first clock edge after release and held 1 (downstream has no backpressure).
//  Beat accepted = s_axis_tvalid & s_axis_tready. Non-accepted cycles: counters/state hold, o_* strobes 0.
//  Latency: accepted beat appears on o_pixel/o_pixel_valid exactly 1 cycle later; o_pixel holds last value
//   when o_pixel_valid=0.
//  FSM states:
//   WAIT_SOF: beats without tuser discarded silently (no error). Beat with tuser: emit as (0,0),
//    o_start_of_frame=1, x<=1 (or x<=0,y<=1 if IMG_WIDTH... n/a, W>=2), -> ACTIVE.
//   ACTIVE: x in 0..W-1, y in 0..H-1, 12-bit each.
//    - normal beat (x<W-1, tlast=0, tuser=0): emit, x<=x+1.
//    - x==W-1 with tlast=1: emit; if y==H-1 emit o_frame_done, x=y=0, -> WAIT_SOF; else x<=0, y<=y+1.
//    - early EOL (tlast=1, x<W-1): error; beat NOT emitted; -> RESYNC.
//    - late EOL (x==W-1, tlast=0): error; beat NOT emitted; -> RESYNC.
//    - early SOF (tuser=1 while in ACTIVE): error, then treated as new frame: emitted as (0,0) with
//      o_start_of_frame=1, x<=1, y<=0, stay ACTIVE. Priority: tuser checked before tlast checks.
//   RESYNC: discard all beats until a tuser beat; that beat handled exactly as in WAIT_SOF.
//  Error: o_err_pulse=1 one cycle after offending beat; o_err_count+1, saturates at 16'hFFFF.
//  tuser+tlast on same beat in WAIT_SOF/RESYNC: accepted as SOF; tlast ignored (W>=2).
//  Reset mid-frame: everything returns to reset values immediately; next frame needs a fresh tuser.
//  o_start_of_frame and o_frame_done only ever asserted together with o_pixel_valid.
// TESTING
//  1 Reset: hold i_aresetn=0 with tvalid=1 -> all outputs 0, tready=0; release -> tready=1 next edge.
//  2 Clean 10x10 frame, tvalid=1 every cycle -> 100 o_pixel_valid pulses, data=input delayed 1 cycle,
//    SOF on first only, o_frame_done on 100th, o_err_count=0.
//  3 Same frame with tvalid toggling 1/0 -> identical output pixel sequence, gaps where tvalid=0.
//  4 Line 3 tlast at x=6 -> o_err_pulse once, o_err_count=1, no further output until next tuser;
//    following clean frame -> 100 pixels, SOF first.
//  5 Line 5 tlast missing at x=9 -> 1 error, RESYNC; tuser asserted at line 7 mid-frame of clean
//    stream -> that beat output as SOF, counting restarts at (0,0).
//  6 Reset asserted at pixel (4,3) -> outputs 0 same cycle; beats before next tuser produce no output.

Source files
------------

// File: rtl/s_axis_video_rx_if.sv
// AXI4-Stream video beat bundle between the upstream source and the receive stage.
interface s_axis_video_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tuser;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/s_axis_video_rx.sv
// Video stream receive stage: checks SOF/EOL geometry and forwards in-frame pixels
// with a one-cycle registered latency. Malformed frames are dropped until the next SOF.
//
// state    | meaning
// WAIT_SOF | idle after reset or a completed frame, discard until a tuser beat
// ACTIVE   | inside a frame, x/y track the position of the next expected beat
// RESYNC   | geometry error seen, discard until a tuser beat
module s_axis_video_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 10,
    parameter int IMG_HEIGHT = 10
) (
    input  logic                  i_clk,
    input  logic                  i_aresetn,
    s_axis_video_rx_if.slave      s_axis,
    output logic [DATA_WIDTH-1:0] o_pixel,
    output logic                  o_pixel_valid,
    output logic                  o_start_of_frame,
    output logic                  o_frame_done,
    output logic                  o_err_pulse,
    output logic [15:0]           o_err_count
);

    localparam logic [11:0] X_LAST = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] Y_LAST = 12'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        RESYNC   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [11:0] x_pos, x_nxt;
    logic [11:0] y_pos, y_nxt;
    logic        tready_q;
    logic        accept;
    logic        emit;
    logic        sof_nxt;
    logic        done_nxt;
    logic        err_nxt;

    assign s_axis.tready = tready_q;
    assign accept        = s_axis.tvalid & tready_q;

    // State, position counters and the always-ready handshake flop.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state    <= WAIT_SOF;
            x_pos    <= '0;
            y_pos    <= '0;
            tready_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            x_pos    <= x_nxt;
            y_pos    <= y_nxt;
            tready_q <= 1'b1;
        end
    end

    // Next-state decode; tuser is evaluated before any tlast check.
    always_comb begin
        state_nxt = state;
        x_nxt     = x_pos;
        y_nxt     = y_pos;
        emit      = 1'b0;
        sof_nxt   = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (accept) begin
            unique case (state)
                WAIT_SOF, RESYNC: begin
                    if (s_axis.tuser) begin
                        emit      = 1'b1;
                        sof_nxt   = 1'b1;
                        x_nxt     = 12'd1;
                        y_nxt     = 12'd0;
                        state_nxt = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (s_axis.tuser) begin
                        err_nxt = 1'b1;
                        emit    = 1'b1;
                        sof_nxt = 1'b1;
                        x_nxt   = 12'd1;
                        y_nxt   = 12'd0;
                    end else if (s_axis.tlast != (x_pos == X_LAST)) begin
                        // EOL on the wrong pixel or missing on the last one
                        err_nxt   = 1'b1;
                        x_nxt     = 12'd0;
                        y_nxt     = 12'd0;
                        state_nxt = RESYNC;
                    end else if (x_pos == X_LAST) begin
                        emit  = 1'b1;
                        x_nxt = 12'd0;
                        if (y_pos == Y_LAST) begin
                            done_nxt  = 1'b1;
                            y_nxt     = 12'd0;
                            state_nxt = WAIT_SOF;
                        end else begin
                            y_nxt = y_pos + 12'd1;
                        end
                    end else begin
                        emit  = 1'b1;
                        x_nxt = x_pos + 12'd1;
                    end
                end
                default: state_nxt = WAIT_SOF;
            endcase
        end
    end

    // Registered pixel output, strobes and saturating error counter.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            o_pixel          <= '0;
            o_pixel_valid    <= 1'b0;
            o_start_of_frame <= 1'b0;
            o_frame_done     <= 1'b0;
            o_err_pulse      <= 1'b0;
            o_err_count      <= '0;
        end else begin
            if (emit) begin
                o_pixel <= s_axis.tdata;
            end
            o_pixel_valid    <= emit;
            o_start_of_frame <= sof_nxt;
            o_frame_done     <= done_nxt;
            o_err_pulse      <= err_nxt;
            if (err_nxt && (o_err_count != 16'hFFFF)) begin
                o_err_count <= o_err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_s_axis_video_rx.sv
// Bench for s_axis_video_rx: frame-level reference model plus directed frame scenarios.
module tb_s_axis_video_rx;
    localparam int W  = 10;
    localparam int H  = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] o_pixel;
    logic          o_pixel_valid, o_sof, o_done, o_err;
    logic [15:0]   o_err_count;

    int total = 0;
    int bad   = 0;
    int n_valid = 0, n_sof = 0, n_done = 0, n_err = 0;

    s_axis_video_rx_if #(.DATA_WIDTH(DW)) ax ();

    s_axis_video_rx #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .i_clk            (clk),
        .i_aresetn        (rst_n),
        .s_axis           (ax.slave),
        .o_pixel          (o_pixel),
        .o_pixel_valid    (o_pixel_valid),
        .o_start_of_frame (o_sof),
        .o_frame_done     (o_done),
        .o_err_pulse      (o_err),
        .o_err_count      (o_err_count)
    );

    always #5 clk = ~clk;

    // Reference model: frame position is a single linear index; a line end is legal
    // exactly when tlast coincides with the last column.
    typedef struct packed {
        logic          ready;
        logic          hunt;
        int            pos;
        int            cnt;
        logic          v;
        logic [DW-1:0] pix;
        logic          sof;
        logic          done;
        logic          err;
    } mst_t;

    localparam mst_t M_RST = '{ready: 1'b0, hunt: 1'b1, pos: 0, cnt: 0, v: 1'b0,
                               pix: '0, sof: 1'b0, done: 1'b0, err: 1'b0};

    mst_t m = M_RST;

    function automatic mst_t step(mst_t s, logic tv, logic [DW-1:0] d, logic u, logic l);
        mst_t n;
        n       = s;
        n.ready = 1'b1;
        n.v     = 1'b0;
        n.sof   = 1'b0;
        n.done  = 1'b0;
        n.err   = 1'b0;
        if (s.ready && tv) begin
            if (s.hunt) begin
                if (u) begin
                    n.v = 1'b1; n.pix = d; n.sof = 1'b1; n.pos = 1; n.hunt = 1'b0;
                end
            end else if (u) begin
                n.err = 1'b1; n.v = 1'b1; n.pix = d; n.sof = 1'b1; n.pos = 1;
            end else if (l != ((s.pos % W) == W - 1)) begin
                n.err = 1'b1; n.hunt = 1'b1; n.pos = 0;
            end else begin
                n.v = 1'b1; n.pix = d;
                if (s.pos == W * H - 1) begin
                    n.done = 1'b1; n.hunt = 1'b1; n.pos = 0;
                end else begin
                    n.pos = s.pos + 1;
                end
            end
            if (n.err && s.cnt < 65535) n.cnt = s.cnt + 1;
        end
        return n;
    endfunction

    // Model update on the same edges the design sees.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= M_RST;
        else        m <= step(m, ax.tvalid, ax.tdata, ax.tuser, ax.tlast);
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        total++;
        if ({ax.tready, o_pixel_valid, o_pixel, o_sof, o_done, o_err, o_err_count} !==
            {m.ready, m.v, m.pix, m.sof, m.done, m.err, 16'(m.cnt)}) begin
            bad++;
            $display("FAIL cycle: got rdy=%0b v=%0b px=%0d sof=%0b done=%0b err=%0b cnt=%0d expected rdy=%0b v=%0b px=%0d sof=%0b done=%0b err=%0b cnt=%0d at %0t",
                     ax.tready, o_pixel_valid, o_pixel, o_sof, o_done, o_err, o_err_count,
                     m.ready, m.v, m.pix, m.sof, m.done, m.err, m.cnt, $time);
        end
        if (o_pixel_valid) n_valid++;
        if (o_sof)         n_sof++;
        if (o_done)        n_done++;
        if (o_err)         n_err++;
    end

    task automatic beat(input logic [DW-1:0] d, input logic u, input logic l);
        @(negedge clk);
        ax.tvalid = 1'b1; ax.tdata = d; ax.tuser = u; ax.tlast = l;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ax.tvalid = 1'b0; ax.tuser = 1'b0; ax.tlast = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] pdat(input int x, input int y, input int seed);
        return DW'(y * W + x + 1 + seed);
    endfunction

    // Lines y_from..y_to; tuser at column 0 of lines sa/sb; optional early tlast
    // (line el, column ex) and missing tlast (line ml); gap idle cycles after each beat.
    task automatic send_lines(input int y_from, input int y_to, input int sa, input int sb,
                              input int el, input int ex, input int ml, input int gap,
                              input int seed);
        logic u, l;
        for (int y = y_from; y <= y_to; y++) begin
            for (int x = 0; x < W; x++) begin
                u = (x == 0) && (y == sa || y == sb);
                if (y == el)      l = (x == ex) || (x == W - 1);
                else if (y == ml) l = 1'b0;
                else              l = (x == W - 1);
                beat(pdat(x, y, seed), u, l);
                if (gap > 0) idle(gap);
            end
        end
    endtask

    int v0, s0, d0, e0;
    task automatic snap();
        v0 = n_valid; s0 = n_sof; d0 = n_done; e0 = n_err;
    endtask

    initial begin
        ax.tvalid = 1'b1; ax.tdata = 8'h55; ax.tuser = 1'b1; ax.tlast = 1'b0;

        // 1: reset held with traffic present
        repeat (3) @(negedge clk);
        chk("rst_tready", int'(ax.tready), 0);
        chk("rst_valid", int'(o_pixel_valid), 0);
        ax.tuser = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("tready_after_release", int'(ax.tready), 1);
        idle(2);

        // 2: clean frame, back-to-back
        snap();
        send_lines(0, H - 1, 0, -1, -1, -1, -1, 0, 0);
        idle(3);
        chk("t2_pixels", n_valid - v0, 100);
        chk("t2_sof", n_sof - s0, 1);
        chk("t2_done", n_done - d0, 1);
        chk("t2_errcnt", int'(o_err_count), 0);
        chk("t2_last_pixel", int'(o_pixel), 100);

        // 3: same frame with tvalid toggling
        snap();
        send_lines(0, H - 1, 0, -1, -1, -1, -1, 1, 3);
        idle(3);
        chk("t3_pixels", n_valid - v0, 100);
        chk("t3_done", n_done - d0, 1);

        // 4: early EOL on line 3 at x=6, then clean frame
        snap();
        send_lines(0, H - 1, 0, -1, 3, 6, -1, 0, 7);
        idle(2);
        chk("t4_pixels_before_resync", n_valid - v0, 36);
        chk("t4_err_pulses", n_err - e0, 1);
        chk("t4_errcnt", int'(o_err_count), 1);
        chk("t4_no_done", n_done - d0, 0);
        send_lines(0, H - 1, 0, -1, -1, -1, -1, 0, 11);
        idle(3);
        chk("t4_pixels_total", n_valid - v0, 136);
        chk("t4_sof", n_sof - s0, 2);
        chk("t4_done", n_done - d0, 1);

        // 5: missing EOL on line 5, tuser at line 7 restarts, stream completes the frame
        snap();
        send_lines(0, H - 1, 0, 7, -1, -1, 5, 0, 20);
        send_lines(3, H - 1, -1, -1, -1, -1, -1, 0, 40);
        idle(3);
        chk("t5_pixels", n_valid - v0, 159);
        chk("t5_err_pulses", n_err - e0, 1);
        chk("t5_errcnt", int'(o_err_count), 2);
        chk("t5_sof", n_sof - s0, 2);
        chk("t5_done", n_done - d0, 1);

        // 6: reset asserted while pixel (4,3) is being presented
        send_lines(0, 2, 0, -1, -1, -1, -1, 0, 50);
        for (int x = 0; x < 4; x++) beat(pdat(x, 3, 50), 1'b0, 1'b0);
        beat(pdat(4, 3, 50), 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_valid_in_reset", int'(o_pixel_valid), 0);
        chk("t6_pixel_in_reset", int'(o_pixel), 0);
        chk("t6_errcnt_in_reset", int'(o_err_count), 0);
        idle(2);
        rst_n = 1'b1;
        snap();
        send_lines(3, H - 1, -1, -1, -1, -1, -1, 0, 60);
        idle(2);
        chk("t6_no_output_without_sof", n_valid - v0, 0);
        send_lines(0, H - 1, 0, -1, -1, -1, -1, 0, 70);
        idle(3);
        chk("t6_clean_pixels", n_valid - v0, 100);
        chk("t6_done", n_done - d0, 1);

        // 7: early SOF on line 2 (with tlast also set elsewhere), frame restarts
        snap();
        send_lines(0, 4, 0, 2, -1, -1, -1, 0, 80);
        send_lines(3, H - 1, -1, -1, -1, -1, -1, 0, 90);
        idle(3);
        chk("t7_pixels", n_valid - v0, 120);
        chk("t7_err", n_err - e0, 1);
        chk("t7_errcnt", int'(o_err_count), 1);
        chk("t7_sof", n_sof - s0, 2);
        chk("t7_done", n_done - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
